// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-bit multiply/divide unit; divide hardware only with MULDIV_DIV_EN
// Shift-add multiply / restoring divide on operand magnitudes, signs applied on the edge into DONE.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] Read_Data1,
  input  logic [31:0] ReadData2_Imm_Output,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Div_By_Zero
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [64:0] acc, acc_step;
  logic [31:0] m_q;
  logic        a_neg, b_neg;
  logic        in_a_neg, in_b_neg;
  logic [31:0] in_a_mag, in_b_mag;
  logic [32:0] mul_sum;
  logic [63:0] prod_res;
`ifdef MULDIV_DIV_EN
  logic        div_q;
  logic [31:0] a_q;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [31:0] quo_res, rem_res;
`endif

  assign in_a_neg = Op[0] & Read_Data1[31];
  assign in_b_neg = Op[0] & ReadData2_Imm_Output[31];
  assign in_a_mag = in_a_neg ? -Read_Data1 : Read_Data1;
  assign in_b_mag = in_b_neg ? -ReadData2_Imm_Output : ReadData2_Imm_Output;

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
`ifdef MULDIV_DIV_EN
          state_nxt = RUN;
`else
          state_nxt = Op[1] ? DONE : RUN;
`endif
        end
      end
      RUN:     if (count == 5'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc holds {carry, partial product, multiplier} or {0, remainder, quotient}
  always_comb begin
    mul_sum  = acc[0] ? (acc[64:32] + {1'b0, m_q}) : acc[64:32];
    acc_step = {1'b0, mul_sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc[63:32], acc[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, m_q};
    if (div_q) begin
      if (div_diff[33]) acc_step = {1'b0, div_shift[31:0], acc[30:0], 1'b0};
      else              acc_step = {1'b0, div_diff[31:0], acc[30:0], 1'b1};
    end
    quo_res = (a_neg ^ b_neg) ? -acc_step[31:0]  : acc_step[31:0];
    rem_res = a_neg           ? -acc_step[63:32] : acc_step[63:32];
`endif
    prod_res = (a_neg ^ b_neg) ? -acc_step[63:0] : acc_step[63:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 5'd0;
      acc         <= '0;
      m_q         <= '0;
      a_neg       <= 1'b0;
      b_neg       <= 1'b0;
      HI          <= '0;
      LO          <= '0;
      Div_By_Zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q       <= 1'b0;
      a_q         <= '0;
`endif
    end else if (state == IDLE && Start) begin
      count <= 5'd31;
      a_neg <= in_a_neg;
      b_neg <= in_b_neg;
`ifdef MULDIV_DIV_EN
      div_q <= Op[1];
      a_q   <= Read_Data1;
      if (Op[1]) begin
        acc <= {33'd0, in_a_mag};
        m_q <= in_b_mag;
      end else begin
        acc <= {33'd0, in_b_mag};
        m_q <= in_a_mag;
      end
`else
      acc <= {33'd0, in_b_mag};
      m_q <= in_a_mag;
`endif
    end else if (state == RUN) begin
      acc <= acc_step;
      if (count != 5'd0) begin
        count <= count - 5'd1;
      end else begin
`ifdef MULDIV_DIV_EN
        if (div_q && m_q == 32'd0) begin
          HI          <= a_q;
          LO          <= 32'hFFFF_FFFF;
          Div_By_Zero <= 1'b1;
        end else if (div_q) begin
          HI          <= rem_res;
          LO          <= quo_res;
          Div_By_Zero <= 1'b0;
        end else begin
          {HI, LO}    <= prod_res;
          Div_By_Zero <= 1'b0;
        end
`else
        {HI, LO}    <= prod_res;
        Div_By_Zero <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
// Divide expectations follow the MULDIV_DIV_EN build option.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] rd1 = '0;
  logic [31:0] rd2 = '0;
  logic        Busy, Done, Div_By_Zero;
  logic [31:0] HI, LO;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic        exp_dbz = 1'b0;
  int          exp_lat = 33;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op),
    .Read_Data1(rd1), .ReadData2_Imm_Output(rd2),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO), .Div_By_Zero(Div_By_Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Reference: plain 64-bit arithmetic; disabled divides leave HI/LO as they were.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    exp_lat = 33;
    exp_dbz = 1'b0;
    case (op)
      2'b00: begin p = {32'd0, a} * {32'd0, b}; {exp_hi, exp_lo} = p; end
      2'b01: begin p = sa * sb; {exp_hi, exp_lo} = p; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          exp_lo = 32'hFFFF_FFFF; exp_hi = a; exp_dbz = 1'b1;
        end else if (op == 2'b10) begin
          exp_lo = a / b; exp_hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          exp_lo = q[31:0]; exp_hi = r[31:0];
        end
`else
        exp_lat = 1;
`endif
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int lat;
    model(op, a, b);
    @(negedge clk);
    Start = 1'b1; Op = op; rd1 = a; rd2 = b;
    @(negedge clk);
    Start = 1'b0; rd1 = $urandom; rd2 = $urandom; Op = 2'($urandom);
    lat = 1;
    n_cmp++;
    if (Busy !== 1'b1) begin n_err++; $display("FAIL %s busy: got %b expected 1", name, Busy); end
    while (Done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat !== exp_lat) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
    n_cmp++;
    if (HI !== exp_hi) begin n_err++; $display("FAIL %s HI: got %h expected %h", name, HI, exp_hi); end
    n_cmp++;
    if (LO !== exp_lo) begin n_err++; $display("FAIL %s LO: got %h expected %h", name, LO, exp_lo); end
    n_cmp++;
    if (Div_By_Zero !== exp_dbz) begin n_err++; $display("FAIL %s dbz: got %b expected %b", name, Div_By_Zero, exp_dbz); end
    @(negedge clk);
    n_cmp++;
    if (Done !== 1'b0 || Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo)
      begin n_err++; $display("FAIL %s after pulse: done=%b busy=%b hi=%h lo=%h expected 0 0 %h %h", name, Done, Busy, HI, LO, exp_hi, exp_lo); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({Busy, Done, Div_By_Zero} !== 3'b000) begin n_err++; $display("FAIL reset flags: got %b expected 000", {Busy, Done, Div_By_Zero}); end
    n_cmp++;
    if ({HI, LO} !== 64'd0) begin n_err++; $display("FAIL reset result: got %h expected 0", {HI, LO}); end
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
  endtask

  task automatic test_directed();
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run_op(2'b10, 32'd100, 32'd0, "divu_by0");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0, "div_neg_by0");
    run_op(2'b10, 32'hFFFF_FFFF, 32'd7, "divu_big");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      run_op(op, pick(), pick(), "random");
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    model(2'b00, a, b);
    @(negedge clk);
    Start = 1'b1; Op = 2'b00; rd1 = a; rd2 = b;
    @(negedge clk);
    Start = 1'b0;
    lat = 1;
    repeat (5) begin @(negedge clk); lat++; end
    Start = 1'b1; Op = 2'b01; rd1 = $urandom; rd2 = $urandom;
    @(negedge clk); lat++;
    Start = 1'b0;
    while (Done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("FAIL ignore latency: got %0d expected 33", lat); end
    n_cmp++;
    if ({HI, LO} !== {exp_hi, exp_lo}) begin n_err++; $display("FAIL ignore result: got %h expected %h", {HI, LO}, {exp_hi, exp_lo}); end
    extra = 0;
    repeat (40) begin @(negedge clk); if (Done === 1'b1) extra++; end
    n_cmp++;
    if (extra !== 0) begin n_err++; $display("FAIL ignore queued: got %0d extra Done pulses expected 0", extra); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "pre_reset");
    @(negedge clk);
    Start = 1'b1; Op = 2'b01; rd1 = $urandom; rd2 = $urandom;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({Busy, Done, Div_By_Zero} !== 3'b000) begin n_err++; $display("FAIL midreset flags: got %b expected 000", {Busy, Done, Div_By_Zero}); end
    n_cmp++;
    if ({HI, LO} !== 64'd0) begin n_err++; $display("FAIL midreset result: got %h expected 0", {HI, LO}); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (Done === 1'b1) pulses++; end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL midreset done: got %0d pulses expected 0", pulses); end
    run_op(2'b01, 32'd12345, 32'hFFFF_FF00, "post_reset");
  endtask

  task automatic test_back_to_back();
    run_op(2'b00, 32'd3, 32'd5, "b2b_first");
    run_op(2'b10, 32'd17, 32'd5, "b2b_div");
    run_op(2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "b2b_last");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
